// File: rtl/ctrl_step_seq.sv
// ctrl_step_seq: T-state step sequencer for a microcoded controller.
// Walks T0..T(N_STEPS-1) per instruction. end_instr from T2 onward cuts an
// instruction short. stall freezes the sequence. halt stops the sequencer
// at the next instruction boundary. Every output comes straight from a flop,
// so downstream decode sees no glitches.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | stepping through T-states
// HALTED  | stopped at an instruction boundary, waiting for start
module ctrl_step_seq #(
    parameter int N_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
    input  logic       stall,
    input  logic       end_instr,
    input  logic [3:0] opcode_in,
    output logic [7:0] t_onehot,
    output logic [2:0] t_count,
    output logic [3:0] opcode,
    output logic       fetch,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0] T_LAST = 3'(N_STEPS - 1);

    state_t     state_q, state_d;
    logic [2:0] t_count_q, t_count_d;
    logic [7:0] t_onehot_q, t_onehot_d;
    logic [3:0] opcode_q, opcode_d;
    logic       fetch_q, fetch_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       halt_pend_q, halt_pend_d;
    logic       boundary;

    // Next state, step counter, instruction register and halt bookkeeping.
    always_comb begin
        state_d     = state_q;
        t_count_d   = t_count_q;
        opcode_d    = opcode_q;
        halt_pend_d = halt_pend_q;
        done_d      = 1'b0;
        boundary    = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = RUN;
                    t_count_d = 3'd0;
                end
            end
            RUN: begin
                if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (!stall) begin
                    // end_instr is only honoured from T2, so fetch always completes.
                    boundary = (t_count_q == T_LAST) ||
                               (end_instr && (t_count_q >= 3'd2));
                    if (t_count_q == 3'd1) begin
                        opcode_d = opcode_in;
                    end
                    if (boundary) begin
                        t_count_d   = 3'd0;
                        done_d      = 1'b1;
                        halt_pend_d = 1'b0;
                        if (halt || halt_pend_q) begin
                            state_d = HALTED;
                        end
                    end else begin
                        t_count_d = t_count_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                t_count_d = 3'd0;
            end
        endcase
    end

    // Output decode from the next-state values, so the outputs can be registered.
    always_comb begin
        running_d  = (state_d == RUN);
        fetch_d    = running_d && (t_count_d <= 3'd1);
        t_onehot_d = 8'd0;
        for (int i = 0; i < N_STEPS; i++) begin
            if (running_d && (t_count_d == 3'(i))) begin
                t_onehot_d[i] = 1'b1;
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t_count_q   <= 3'd0;
            t_onehot_q  <= 8'd0;
            opcode_q    <= 4'd0;
            fetch_q     <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_count_q   <= t_count_d;
            t_onehot_q  <= t_onehot_d;
            opcode_q    <= opcode_d;
            fetch_q     <= fetch_d;
            running_q   <= running_d;
            done_q      <= done_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign t_onehot = t_onehot_q;
    assign t_count  = t_count_q;
    assign opcode   = opcode_q;
    assign fetch    = fetch_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: doc/ctrl_step_seq.md
CTRL_STEP_SEQ -- requirements
Module: ctrl_step_seq

Interface
REQ-001 Parameter N_STEPS, default 6: T-states per instruction; legal range 3..8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  begin or resume execution from IDLE or HALTED.
REQ-005 halt  input  1  halt request, honoured at the next instruction boundary.
REQ-006 stall  input  1  freeze the step counter for the current cycle.
REQ-007 end_instr  input  1  early instruction completion from microcode.
REQ-008 opcode_in  input  4  instruction opcode from the fetch path.
REQ-009 t_onehot  output  8  one-hot current T-state; bit i high means step Ti; feeds the quad AND-gate decode stage.
REQ-010 t_count  output  3  binary current T-state index.
REQ-011 opcode  output  4  latched instruction register.
REQ-012 fetch  output  1  high in T0 and T1 while running.
REQ-013 running  output  1  high in state RUN.
REQ-014 done  output  1  one-cycle pulse after each completed instruction.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and HALTED.
REQ-016 IDLE or HALTED with start=1 SHALL go to RUN with t_count=0 on the next edge; start SHALL be ignored in RUN.
REQ-017 In RUN with stall=0, t_count SHALL increment by 1 per edge, except at an instruction boundary.
REQ-018 An instruction boundary SHALL occur when t_count==N_STEPS-1, or when end_instr=1 and t_count>=2.
REQ-019 end_instr SHALL be ignored in T0 and T1, so fetch is never cut short.
REQ-020 At a boundary edge, t_count SHALL return to 0 and done SHALL be high for the following single cycle only.
REQ-021 With stall=1, t_count, opcode and the FSM state SHALL hold, and end_instr SHALL be ignored.
REQ-022 opcode SHALL load opcode_in on an edge in RUN with t_count==1 and stall=0; otherwise it SHALL hold.
REQ-023 A halt_pend flag SHALL set on any edge in RUN with halt=1, including stalled cycles.
REQ-024 At a boundary edge, if halt=1 or halt_pend=1, the next state SHALL be HALTED, t_count SHALL be 0, halt_pend SHALL clear and done SHALL still pulse.
REQ-025 In IDLE or HALTED, halt SHALL be ignored; start with halt=1 SHALL enter RUN.
REQ-026 Output decode:
- t_onehot[i] SHALL equal running AND (t_count==i).
- t_onehot SHALL be 0 outside RUN.
- Bits at or above N_STEPS SHALL never assert.
REQ-027 fetch SHALL equal running AND (t_count<=1); running SHALL be a registered output.
REQ-028 No output SHALL glitch on a stall edge or a non-boundary edge.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force:
- state IDLE;
- t_count=0, t_onehot=0;
- opcode=0, fetch=0;
- running=0, done=0, halt_pend=0.
REQ-030 Reset during RUN SHALL abandon the instruction in progress; the first start after rst_n rises SHALL begin at T0.
REQ-031 On the first clock edge after deassertion, start=1 SHALL be honoured.

Verification (N_STEPS=6)
REQ-032 Reset then start pulse:
- t_onehot SHALL step 01,02,04,08,10,20 then 01.
- done SHALL be high in the cycle after T5.
- fetch SHALL be high in T0 and T1 only.
REQ-033 opcode_in=4'b1010 during T1:
- opcode SHALL read 1010 from T2 onward.
- opcode_in=4'b0101 at T3 SHALL leave opcode at 1010.
REQ-034 end_instr=1 at T3 SHALL give next t_onehot=01 and a done pulse; end_instr=1 at T1 SHALL give next t_onehot=04.
REQ-035 stall=1 for 3 cycles at T2 SHALL hold t_onehot=04 for 4 cycles total, then advance to 08.
REQ-036 halt pulse at T2:
- Execution SHALL continue to T5, then running SHALL go 0, t_onehot=00 and done=1.
- A later start SHALL resume at T0.
REQ-037 rst_n dropped mid-T4 SHALL zero all outputs before the next clock edge.
